pipe_cla_addsub: RTL and testbench
==================================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter GROUP, default 4, bits per lookahead group.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  2  operation, encoded as op_t: ADD=0, SUB=1, ADC=2, SBB=3.
REQ-010 SHALL have port cin  input  1  carry-in; used by ADC/SBB only.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  result beat consumed when out_valid && out_ready.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB (SUB/SBB: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port zero  output  1  sum == 0.

Function
REQ-017 SHALL support only GROUP in {2,4,8} with WIDTH a multiple of GROUP, WIDTH >= GROUP; other values SHALL fail elaboration.
REQ-018 Operand prep: ADD b'=b, c0=0; SUB b'=~b, c0=1; ADC b'=b, c0=cin; SBB b'=~b, c0=cin (cin=1 means no borrow).
REQ-019 Stage 1 SHALL register per-group propagate Pg=AND(p) and generate Gg=group lookahead generate, plus a, b', c0, op.
REQ-020 Stage 2 SHALL compute group carries C(k+1)=Gg(k) | Pg(k)&C(k) via lookahead across groups, ripple-free, then register sum, cout, ovf, zero.
REQ-021 Latency SHALL be exactly 2 cycles from acceptance to out_valid with out_ready held high; throughput one beat per cycle.
REQ-022 Stage n SHALL advance when it is empty or the next stage advances; stage 2 advances when !out_valid || out_ready.
REQ-023 in_ready SHALL equal !s1_valid || stage-1 advance; combinational from out_ready, never from in_valid.
REQ-024 While out_valid && !out_ready, sum/cout/ovf/zero SHALL hold stable.
REQ-025 With both stages full and out_ready low, in_ready SHALL be 0; no beat SHALL be dropped or duplicated, order SHALL be preserved.
REQ-026 Simultaneous accept and drain in one cycle SHALL be lossless at full throughput.
REQ-027 ovf SHALL be (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]).

Reset
REQ-028 reset_n low SHALL asynchronously clear both stage valids; out_valid=0, in_ready=1 while held low.
REQ-029 Reset SHALL clear sum, cout, ovf, zero to 0; in-flight beats SHALL be discarded.
REQ-030 First acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-031 Macro PIPE_CLA_SAT_EN defined: on ovf, sum SHALL saturate to 0x7F.. (positive overflow) or 0x80.. (negative); ovf still reported; zero computed on saturated sum.
REQ-032 Macro undefined: sum SHALL wrap modulo 2^WIDTH; no saturation logic present.

Structure
REQ-033 Package cla_pkg SHALL hold op_t enum, GROUP legality check function, and group-count function WIDTH/GROUP.
REQ-034 Sub-module cla_group SHALL compute one group's Pg/Gg and its GROUP-bit sum from a group carry-in; instantiated WIDTH/GROUP times.

Verification (WIDTH=8, GROUP=4, macro off unless noted)
REQ-035 ADD 0x7F+0x01 -> 2 cycles later sum=0x80, cout=0, ovf=1, zero=0.
REQ-036 SUB 0x05-0x05 -> sum=0x00, cout=1, ovf=0, zero=1; ADD 0xFF+0x01 -> sum=0x00, cout=1, zero=1.
REQ-037 ADC 0x0F+0x00 cin=1 -> sum=0x10 (carry crosses group boundary); SBB 0x10-0x01 cin=0 -> sum=0x0E.
REQ-038 out_ready low 4 cycles, 3 back-to-back ADD beats offered -> 2 accepted, in_ready=0 after, all 3 emerge in order once out_ready high.
REQ-039 reset_n pulsed low with both stages full -> out_valid=0 same cycle without clock edge; no stale beat after release.
REQ-040 PIPE_CLA_SAT_EN defined: ADD 0x7F+0x01 -> sum=0x7F, ovf=1; SUB 0x80-0x01 -> sum=0x80, ovf=1.

Source files
------------

// File: rtl/cla_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_pkg                                                                    |
// | Shared types and elaboration helpers for the pipelined CLA add/sub unit.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBB = 2'd3
  } op_t;

  function automatic bit group_legal(input int width, input int group);
    return ((group == 2) || (group == 4) || (group == 8)) &&
           (width >= group) && ((width % group) == 0);
  endfunction

  function automatic int num_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_group                                                                  |
// | One lookahead group: Pg/Gg from the stage-1 operands and the group sum     |
// | from the registered operands plus the lookahead group carry-in.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_pa,
  input  logic [GROUP-1:0] i_pb,
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_cin,
  output logic             o_pg,
  output logic             o_gg,
  output logic [GROUP-1:0] o_sum
);

  always_comb begin : lookahead
    logic gacc;
    gacc = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      gacc = (i_pa[i] & i_pb[i]) | ((i_pa[i] ^ i_pb[i]) & gacc);
    end
    o_gg = gacc;
    o_pg = &(i_pa ^ i_pb);
  end

  // Carry stays inside the group; only GROUP bits deep.
  always_comb begin : bit_sum
    logic c;
    c     = i_cin;
    o_sum = '0;
    for (int i = 0; i < GROUP; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & c);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_cla_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_cla_addsub                                                            |
// | Two-stage valid/ready carry-lookahead add/subtract (ADD/SUB/ADC/SBB).      |
// | Define PIPE_CLA_SAT_EN to saturate the sum on signed overflow.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipe_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int c_ngrp = num_groups(WIDTH, GROUP);
  localparam int c_msb  = WIDTH - 1;

  if (!group_legal(WIDTH, GROUP)) begin : g_bad_cfg
    $fatal(1, "pipe_cla_addsub: GROUP must be 2, 4 or 8 and divide WIDTH");
  end

  op_t               w_op;
  logic [WIDTH-1:0]  w_bp;
  logic              w_c0;
  logic [c_ngrp-1:0] w_pg, w_gg;
  logic [c_ngrp:0]   w_c;
  logic [WIDTH-1:0]  w_sum_raw, w_sum_fin;
  logic              w_ovf;
  logic              w_s1_adv, w_s2_adv;

  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_a, r_bp;
  logic              r_c0;
  logic [c_ngrp-1:0] r_pg, r_gg;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout, r_ovf, r_zero;

  assign w_op     = op_t'(op);
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    w_bp = b;
    w_c0 = 1'b0;
    case (w_op)
      OP_ADD:  begin w_bp = b;  w_c0 = 1'b0; end
      OP_SUB:  begin w_bp = ~b; w_c0 = 1'b1; end
      OP_ADC:  begin w_bp = b;  w_c0 = cin;  end
      OP_SBB:  begin w_bp = ~b; w_c0 = cin;  end
      default: begin w_bp = b;  w_c0 = 1'b0; end
    endcase
  end

  for (genvar k = 0; k < c_ngrp; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_pa  (a[k*GROUP +: GROUP]),
      .i_pb  (w_bp[k*GROUP +: GROUP]),
      .i_a   (r_a[k*GROUP +: GROUP]),
      .i_b   (r_bp[k*GROUP +: GROUP]),
      .i_cin (w_c[k]),
      .o_pg  (w_pg[k]),
      .o_gg  (w_gg[k]),
      .o_sum (w_sum_raw[k*GROUP +: GROUP])
    );
  end

  // Each group carry is a flat sum of products over the registered Pg/Gg,
  // so no carry depends on another group's computed carry.
  always_comb begin : lookahead
    logic t, prop;
    w_c    = '0;
    w_c[0] = r_c0;
    for (int k = 0; k < c_ngrp; k++) begin
      t    = r_gg[k];
      prop = r_pg[k];
      for (int j = k - 1; j >= 0; j--) begin
        t    = t | (prop & r_gg[j]);
        prop = prop & r_pg[j];
      end
      w_c[k+1] = t | (prop & r_c0);
    end
  end

  assign w_ovf = (r_a[c_msb] == r_bp[c_msb]) && (w_sum_raw[c_msb] != r_a[c_msb]);

`ifdef PIPE_CLA_SAT_EN
  assign w_sum_fin = !w_ovf        ? w_sum_raw :
                     r_a[c_msb]    ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_sum_fin = w_sum_raw;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_bp       <= '0;
      r_c0       <= 1'b0;
      r_pg       <= '0;
      r_gg       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a  <= a;
        r_bp <= w_bp;
        r_c0 <= w_c0;
        r_pg <= w_pg;
        r_gg <= w_gg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum_fin;
        r_cout <= w_c[c_ngrp];
        r_ovf  <= w_ovf;
        r_zero <= (w_sum_fin == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipe_cla_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_cla_addsub                                                         |
// | Self-checking bench: directed vector table, pipeline corner sequences and  |
// | randomized traffic against an arithmetic reference model.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pipe_cla_addsub;

  logic       clk;
  logic       reset_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       cin;
  logic       out_valid, out_ready;
  logic [7:0] sum;
  logic       cout, ovf, zero;

  pipe_cla_addsub #(.WIDTH(8), .GROUP(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef PIPE_CLA_SAT_EN
  localparam logic [7:0] c_pos_ovf_sum = 8'h7F;
  localparam logic [7:0] c_neg_ovf_sum = 8'h80;
  localparam logic [7:0] c_8080_sum    = 8'h80;
  localparam logic       c_8080_zero   = 1'b0;
`else
  localparam logic [7:0] c_pos_ovf_sum = 8'h80;
  localparam logic [7:0] c_neg_ovf_sum = 8'h7F;
  localparam logic [7:0] c_8080_sum    = 8'h00;
  localparam logic       c_8080_zero   = 1'b1;
`endif

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [10:0] v;
    string       tag;
  } sb_t;

  localparam int c_nv = 13;
  vec_t vt [c_nv];
  sb_t  exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  bit done    = 1'b0;

  logic [7:0] ra, rb;
  logic [1:0] rop;
  logic       rc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic logic [10:0] ref_model(input logic [1:0] f_op, input logic [7:0] f_a,
                                            input logic [7:0] f_b, input logic f_cin);
    logic [7:0] bp, s;
    int c0, u, sv;
    logic ov;
    bp = f_op[0] ? ~f_b : f_b;
    c0 = (f_op == 2'd0) ? 0 : (f_op == 2'd1) ? 1 : int'(f_cin);
    u  = int'(f_a) + int'(bp) + c0;
    sv = int'($signed(f_a)) + int'($signed(bp)) + c0;
    s  = u[7:0];
    ov = (sv > 127) || (sv < -128);
`ifdef PIPE_CLA_SAT_EN
    if (ov) s = (sv > 127) ? 8'h7F : 8'h80;
`endif
    return {s, (u > 255), ov, (s == 8'h00)};
  endfunction

  task automatic send(input logic [1:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                      input logic t_cin, input logic [10:0] t_exp, input string t_tag);
    int n;
    op = t_op; a = t_a; b = t_b; cin = t_cin; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout_%s: in_ready=0, required 1", t_tag);
    end else begin
      exp_q.push_back('{v: t_exp, tag: t_tag});
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard: drained beats must match in order; stalled beats must show the head entry.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h, required no beat", {sum, cout, ovf, zero});
      end else if (out_ready) begin
        sb_t e;
        e = exp_q.pop_front();
        check({"out_", e.tag}, {sum, cout, ovf, zero}, e.v);
      end else begin
        check({"stall_", exp_q[0].tag}, {sum, cout, ovf, zero}, exp_q[0].v);
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int lat;
    bit stale;
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b1;

    vt[0]  = '{"add_7f_01", 2'd0, 8'h7F, 8'h01, 1'b0, c_pos_ovf_sum, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{"sub_05_05", 2'd1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{"add_ff_01", 2'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{"adc_0f_00", 2'd2, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{"sbb_10_01", 2'd3, 8'h10, 8'h01, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{"sub_80_01", 2'd1, 8'h80, 8'h01, 1'b0, c_neg_ovf_sum, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{"sub_00_01", 2'd1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{"adc_ff_ff", 2'd2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{"sbb_00_00", 2'd3, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{"add_80_80", 2'd0, 8'h80, 8'h80, 1'b1, c_8080_sum, 1'b1, 1'b1, c_8080_zero};
    vt[10] = '{"sbb_05_03", 2'd3, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
    vt[11] = '{"add_ff_ff", 2'd0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vt[12] = '{"adc_0f_f0", 2'd2, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, in_ready, sum, cout, ovf, zero}, {1'b0, 1'b1, 8'h00, 3'b000});

    // Release and offer the first beat together: accepted on the first rising edge.
    reset_n = 1'b1;
    op = vt[0].op; a = vt[0].a; b = vt[0].b; cin = vt[0].cin; in_valid = 1'b1;
    exp_q.push_back('{v: {vt[0].sum, vt[0].cout, vt[0].ovf, vt[0].zero}, tag: vt[0].name});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 2);

    for (int i = 1; i < c_nv; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].cin,
           {vt[i].sum, vt[i].cout, vt[i].ovf, vt[i].zero}, vt[i].name);
    end
    wait_empty("table_drain");

    // Backpressure: three beats offered while out_ready is low for four cycles.
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          send(2'd0, 8'h10 + 8'(k), 8'h01, 1'b0,
               ref_model(2'd0, 8'h10 + 8'(k), 8'h01, 1'b0), $sformatf("bp%0d", k));
        end
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", n_acc, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_empty("bp_drain");

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(2'd0, 8'h21, 8'h02, 1'b0, ref_model(2'd0, 8'h21, 8'h02, 1'b0), "rst0");
    send(2'd1, 8'h40, 8'h03, 1'b0, ref_model(2'd1, 8'h40, 8'h03, 1'b0), "rst1");
    check("rst_pre_full", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    check("rst_async_data", {sum, cout, ovf, zero}, 11'h000);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rst_no_stale", stale, 0);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom); rc = 1'($urandom);
          send(rop, ra, rb, rc, ref_model(rop, ra, rb, rc), $sformatf("rnd%0d", k));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_empty("rnd_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
